// File: rtl/wb_pkg.sv
// Shared types and default widths for the Wishbone initiator port.
package wb_pkg;

    localparam int WB_AW = 16;
    localparam int WB_DW = 16;
    localparam int WB_SW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic             we;
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] wdata;
        logic [WB_SW-1:0] sel;
    } wb_req_t;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Counts strobe cycles without acknowledge; flags the last allowed cycle.
module wb_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT > 0) begin : g_cnt
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear) begin
                    cnt_d = '0;
                end else if (enable) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expired = (cnt_q == LAST);
        end else begin : g_none
            // A zero limit means the port waits for an acknowledge forever.
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/wb_master_port.sv
// Core-side Wishbone classic initiator: one request in, one bus cycle, one response out.
module wb_master_port
    import wb_pkg::*;
#(
    parameter int AW      = wb_pkg::WB_AW,
    parameter int DW      = wb_pkg::WB_DW,
    parameter int SW      = wb_pkg::WB_SW,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_adr,
    input  logic [DW-1:0] req_wdata,
    input  logic [SW-1:0] req_sel,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] adr_out,
    output logic [DW-1:0] data_out,
    output logic          we_out,
    output logic [SW-1:0] sel_out,
    output logic          stb_out,
    output logic          cyc_out,
    input  logic [DW-1:0] data_in,
    input  logic          akn_in,
    output logic [1:0]    dbg_state_o
);

    // Core handshake: a request transfers on an edge where req_valid and
    // req_ready are both high; req_ready depends only on state, never on
    // req_valid, and the core holds its request until that edge.

    wb_state_e     state_q, state_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          stb_q, stb_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          expired;

    wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q != BUSY),
        .enable  ((state_q == BUSY) && !akn_in),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        sel_d       = sel_q;
        stb_d       = stb_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    adr_d   = req_adr;
                    wdata_d = req_wdata;
                    we_d    = req_we;
                    sel_d   = req_sel;
                    stb_d   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Acknowledge is tested first so it beats a same-cycle expiry.
                if (akn_in) begin
                    rdata_d     = we_q ? '0 : data_in;
                    err_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    stb_d       = 1'b0;
                    state_d     = RESP;
                end else if (expired) begin
                    rdata_d     = '0;
                    err_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    stb_d       = 1'b0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                stb_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            stb_q       <= stb_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign adr_out     = adr_q;
    assign data_out    = wdata_q;
    assign we_out      = we_q;
    assign sel_out     = sel_q;
    assign stb_out     = stb_q;
    assign cyc_out     = stb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_master_port.sv
// Directed bench for wb_master_port with hand-computed expectations.
module tb_wb_master_port;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_adr;
  logic [15:0] req_wdata;
  logic [3:0]  req_sel;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] adr_out;
  logic [15:0] data_out;
  logic        we_out;
  logic [3:0]  sel_out;
  logic        stb_out;
  logic        cyc_out;
  logic [15:0] data_in;
  logic        akn_in;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int stb_cycles;
  int rsp_count;

  wb_master_port #(.AW(16), .DW(16), .SW(4), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_adr     (req_adr),
    .req_wdata   (req_wdata),
    .req_sel     (req_sel),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .adr_out     (adr_out),
    .data_out    (data_out),
    .we_out      (we_out),
    .sel_out     (sel_out),
    .stb_out     (stb_out),
    .cyc_out     (cyc_out),
    .data_in     (data_in),
    .akn_in      (akn_in),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [15:0] adr,
                           input logic [15:0] wdata, input logic [3:0] sel);
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = adr;
    req_wdata = wdata;
    req_sel   = sel;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_adr   = '0;
    req_wdata = '0;
    req_sel   = '0;
    data_in   = '0;
    akn_in    = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_stb", 32'(stb_out), 0);
    check("rst_cyc", 32'(cyc_out), 0);
    check("rst_we", 32'(we_out), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_adr", 32'(adr_out), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_sel", 32'(sel_out), 0);
    check("rst_rdata", 32'(rsp_rdata), 0);
    rst = 1'b1;
    tick();
    check("rst_ready", 32'(req_ready), 1);
    check("rst_state", 32'(dbg_state), 0);

    // read, zero-wait slave
    drive_req(1'b0, 16'h0040, 16'h0000, 4'hF);
    tick();
    req_valid = 1'b0;
    check("rd_stb", 32'(stb_out), 1);
    check("rd_cyc", 32'(cyc_out), 1);
    check("rd_we", 32'(we_out), 0);
    check("rd_adr", 32'(adr_out), 32'h0040);
    check("rd_ready_busy", 32'(req_ready), 0);
    check("rd_state_busy", 32'(dbg_state), 1);
    akn_in  = 1'b1;
    data_in = 16'hBEEF;
    tick();
    akn_in = 1'b0;
    check("rd_stb_drop", 32'(stb_out), 0);
    check("rd_rsp_valid", 32'(rsp_valid), 1);
    check("rd_rdata", 32'(rsp_rdata), 32'hBEEF);
    check("rd_err", 32'(rsp_err), 0);
    check("rd_we_resp", 32'(we_out), 0);
    check("rd_ready_resp", 32'(req_ready), 0);
    tick();
    check("rd_rsp_one_cycle", 32'(rsp_valid), 0);
    check("rd_ready_again", 32'(req_ready), 1);
    check("rd_rdata_held", 32'(rsp_rdata), 32'hBEEF);

    // write, three wait states
    drive_req(1'b1, 16'h0100, 16'h1234, 4'hF);
    data_in = 16'h5555;
    tick();
    req_valid = 1'b0;
    req_adr   = 16'hFFFF;
    req_wdata = 16'hFFFF;
    req_we    = 1'b0;
    req_sel   = 4'h0;
    for (int i = 0; i < 4; i++) begin
      check("wr_stb", 32'(stb_out), 1);
      check("wr_adr", 32'(adr_out), 32'h0100);
      check("wr_data", 32'(data_out), 32'h1234);
      check("wr_we", 32'(we_out), 1);
      check("wr_sel", 32'(sel_out), 32'hF);
      check("wr_no_rsp", 32'(rsp_valid), 0);
      if (i == 3) akn_in = 1'b1;
      tick();
    end
    akn_in = 1'b0;
    check("wr_rsp_valid", 32'(rsp_valid), 1);
    check("wr_rdata_zero", 32'(rsp_rdata), 0);
    check("wr_err", 32'(rsp_err), 0);
    check("wr_stb_drop", 32'(stb_out), 0);
    tick();

    // timeout: slave never acknowledges
    drive_req(1'b0, 16'h0200, 16'h0000, 4'h3);
    tick();
    req_valid  = 1'b0;
    stb_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (stb_out !== 1'b1) break;
      stb_cycles++;
      tick();
    end
    check("to_stb_cycles", 32'(stb_cycles), 15);
    check("to_rsp_valid", 32'(rsp_valid), 1);
    check("to_rsp_err", 32'(rsp_err), 1);
    check("to_rdata", 32'(rsp_rdata), 0);
    check("to_state_resp", 32'(dbg_state), 2);
    tick();
    check("to_ready", 32'(req_ready), 1);
    check("to_rsp_clear", 32'(rsp_valid), 0);
    check("to_err_held", 32'(rsp_err), 1);

    // ack in the 15th BUSY cycle beats expiry
    drive_req(1'b0, 16'h0300, 16'h0000, 4'hF);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check("bd_stb_cycle15", 32'(stb_out), 1);
    akn_in  = 1'b1;
    data_in = 16'hA5A5;
    tick();
    akn_in = 1'b0;
    check("bd_rsp_valid", 32'(rsp_valid), 1);
    check("bd_rsp_err", 32'(rsp_err), 0);
    check("bd_rdata", 32'(rsp_rdata), 32'hA5A5);
    tick();
    check("bd_ready", 32'(req_ready), 1);

    // back-to-back reads with a permanently acknowledging slave
    drive_req(1'b0, 16'h0400, 16'h0000, 4'hF);
    akn_in    = 1'b1;
    data_in   = 16'h1000;
    rsp_count = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("b2b_stb", 32'(stb_out), (i % 3 == 1) ? 1 : 0);
      check("b2b_rsp", 32'(rsp_valid), (i % 3 == 2) ? 1 : 0);
      check("b2b_ready", 32'(req_ready), (i % 3 == 0) ? 1 : 0);
      if (rsp_valid === 1'b1) begin
        rsp_count++;
        check("b2b_rdata", 32'(rsp_rdata), 32'h1000);
      end
    end
    check("b2b_rsp_count", 32'(rsp_count), 4);

    // spurious acknowledge while idle
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("noise_rsp", 32'(rsp_valid), 0);
      check("noise_stb", 32'(stb_out), 0);
      check("noise_ready", 32'(req_ready), 1);
    end
    akn_in = 1'b0;

    // reset in the second BUSY cycle
    drive_req(1'b0, 16'h0500, 16'h0000, 4'hF);
    tick();
    req_valid = 1'b0;
    tick();
    check("mr_stb_busy2", 32'(stb_out), 1);
    #2;
    rst = 1'b0;
    #1;
    check("mr_stb_async", 32'(stb_out), 0);
    check("mr_cyc_async", 32'(cyc_out), 0);
    tick();
    check("mr_no_rsp", 32'(rsp_valid), 0);
    rst = 1'b1;
    tick();
    check("mr_ready", 32'(req_ready), 1);
    check("mr_no_rsp_after", 32'(rsp_valid), 0);
    check("mr_stb_after", 32'(stb_out), 0);
    check("mr_err_after", 32'(rsp_err), 0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
